// File: rtl/leg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | leg_pkg: LEGv8 immediate formats, opcode patterns, entry type   |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package leg_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_I    = 3'd2,
    FMT_CB   = 3'd3,
    FMT_B    = 3'd4,
    FMT_IW   = 3'd5
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // Patterns on instr[31:21], matched with casez
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_CBNZ = 11'b10110101???;
  localparam logic [10:0] OP_B    = 11'b000101?????;
  localparam logic [10:0] OP_BL   = 11'b100101?????;
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_SUBI = 11'b1101000100?;
  localparam logic [10:0] OP_MOVZ = 11'b110100101??;

  typedef struct packed {
    logic [MAX_N-1:0] imm;
    imm_fmt_t         fmt;
    logic             illegal;
  } imm_entry_t;

  localparam imm_entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

endpackage
`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | imm_extend_pipe_if: instruction-in / immediate-out handshake    |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
interface imm_extend_pipe_if
  import leg_pkg::*;
#(
  parameter int N = 64
) ();

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  instr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] imm;
  logic [N-1:0] br_off;
  imm_fmt_t     fmt;
  logic         illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, imm, br_off, fmt, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, imm, br_off, fmt, illegal
  );

endinterface
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | imm_decode: combinational LEGv8 immediate extraction/extension  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module imm_decode
  import leg_pkg::*;
#(
  parameter int N = 64
) (
  input  wire logic [31:0] i_instr,
  output imm_entry_t       o_entry
);

  logic [63:0] w_ext;
  imm_fmt_t    w_fmt;
  logic        w_illegal;

  always_comb begin
    w_ext     = '0;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    casez (i_instr[31:21])
      OP_LDUR, OP_STUR: begin
        w_fmt = FMT_D;
        w_ext = {{55{i_instr[20]}}, i_instr[20:12]};
      end
      OP_CBZ, OP_CBNZ: begin
        w_fmt = FMT_CB;
        w_ext = {{45{i_instr[23]}}, i_instr[23:5]};
      end
      OP_B, OP_BL: begin
        w_fmt = FMT_B;
        w_ext = {{38{i_instr[25]}}, i_instr[25:0]};
      end
      OP_ADDI, OP_SUBI: begin
        w_fmt = FMT_I;
        w_ext = {52'b0, i_instr[21:10]};
      end
      OP_MOVZ: begin
        w_fmt = FMT_IW;
        // hw >= 2 places the halfword entirely above a 32-bit datapath
        if (N == 32 && i_instr[22]) begin
          w_illegal = 1'b1;
        end else begin
          w_ext = {48'b0, i_instr[20:5]} << {i_instr[22:21], 4'b0000};
        end
      end
      default: begin
        w_fmt = FMT_NONE;
      end
    endcase
  end

  assign o_entry = '{imm: w_ext, fmt: w_fmt, illegal: w_illegal};

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | imm_extend_pipe: registered immediate generator, 2-entry skid   |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module imm_extend_pipe
  import leg_pkg::*;
#(
  parameter int N = 64
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         flush,
  imm_extend_pipe_if.slave  bus
);

  if (N != 32 && N != 64) begin : g_bad_n
    $error("imm_extend_pipe: N must be 32 or 64");
  end

  imm_entry_t  w_dec;
  imm_entry_t  r_main;
  imm_entry_t  r_skid;
  pipe_state_t r_state;
  logic        r_out_valid;
  logic        r_in_ready;
  logic        w_in_xfer;
  logic        w_out_xfer;

  imm_decode #(.N(N)) u_dec (
    .i_instr (bus.instr),
    .o_entry (w_dec)
  );

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= ENTRY_RST;
      r_skid      <= ENTRY_RST;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_main      <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_dec;
          end else if (w_in_xfer) begin
            r_skid     <= w_dec;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.imm       = r_main.imm[N-1:0];
  assign bus.br_off    = {r_main.imm[N-3:0], 2'b00};
  assign bus.fmt       = r_main.fmt;
  assign bus.illegal   = r_main.illegal;

endmodule
`default_nettype wire
